piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 105 ++++++++++
 tb/tb_piso_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer: MSB-first frames with a ready/valid load port and back-to-back streaming.
// Optional even-parity trailer bit when SERIAL_PARITY_EN is defined.
module piso_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);

`ifdef SERIAL_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shreg;
   logic             last_bit;
   logic             final_cycle;
   logic             accept;

   assign last_bit = (state == SHIFT) && (count == LAST);

`ifdef SERIAL_PARITY_EN
   logic parity;
   assign final_cycle = (state == PARITY);
`else
   assign final_cycle = last_bit;
`endif

   assign load_ready = (state == IDLE) || final_cycle;
   assign accept     = load_valid && load_ready;
   assign busy       = (state != IDLE);

   // shreg holds the bits still to be sent, left-aligned; ser_out already shows the current bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         shreg     <= '0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         done      <= 1'b0;
`ifdef SERIAL_PARITY_EN
         parity    <= 1'b0;
`endif
      end else if (accept) begin
         state     <= SHIFT;
         count     <= '0;
         shreg     <= {load_data[WIDTH-2:0], 1'b0};
         ser_out   <= load_data[WIDTH-1];
         ser_valid <= 1'b1;
         done      <= 1'b0;
`ifdef SERIAL_PARITY_EN
         parity    <= ^load_data;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (last_bit) begin
`ifdef SERIAL_PARITY_EN
                  state     <= PARITY;
                  ser_out   <= parity;
                  ser_valid <= 1'b1;
                  done      <= 1'b1;
`else
                  state     <= IDLE;
                  ser_out   <= 1'b0;
                  ser_valid <= 1'b0;
                  done      <= 1'b0;
`endif
               end else begin
                  count     <= count + 1'b1;
                  ser_out   <= shreg[WIDTH-1];
                  shreg     <= shreg << 1;
                  ser_valid <= 1'b1;
`ifdef SERIAL_PARITY_EN
                  done      <= 1'b0;
`else
                  done      <= (count == LAST_M1);
`endif
               end
            end
            default: begin
               // IDLE, or the parity trailer finished with no follow-on word
               state     <= IDLE;
               ser_out   <= 1'b0;
               ser_valid <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: table-driven frames plus back-to-back, ignored-load and reset sequences.
module tb_piso_serializer;
   localparam int W = 8;
`ifdef SERIAL_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         load_valid = 1'b0;
   logic [W-1:0] load_data = '0;
   logic         load_ready, ser_out, ser_valid, busy, done;

   piso_serializer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic bit_v;
      logic done_v;
   } exp_t;
   exp_t q[$];

   typedef struct {
      logic [W-1:0] data;
      logic         exp_parity;
      int           exp_det;
      int           exp_det_p;
   } vec_t;
   vec_t vec[4];

   int pass_cnt = 0;
   int total_cnt = 0;
   int done_cnt = 0;
   int det_cnt = 0;
   int run = 0;
   int max_run = 0;
   int nb = 0;
   logic [2:0] hist = '0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // Scoreboard and downstream 101-detector model, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         if (q.size() > 0) begin
            check("ser_valid_live", ser_valid, 1);
            check("ser_out", ser_out, q[0].bit_v);
            check("done", done, q[0].done_v);
            check("load_ready_frame", load_ready, (q.size() == 1));
            void'(q.pop_front());
         end else begin
            check("ser_valid_idle", ser_valid, 0);
            check("ser_out_idle", ser_out, 0);
            check("done_idle", done, 0);
            check("load_ready_idle", load_ready, 1);
         end
         check("busy", busy, ser_valid);
         if (done) done_cnt++;
         if (ser_valid) begin
            hist = {hist[1:0], ser_out};
            nb++;
            run++;
            if (run > max_run) max_run = run;
            if (nb >= 3 && hist == 3'b101) det_cnt++;
         end else begin
            nb = 0;
            run = 0;
         end
      end
   end

   task automatic push_word(input logic [W-1:0] d, input logic p);
      exp_t e;
      for (int i = W - 1; i >= 0; i--) begin
         e.bit_v  = d[i];
         e.done_v = (i == 0) && !PAR_EN;
         q.push_back(e);
      end
      if (PAR_EN) begin
         e.bit_v  = p;
         e.done_v = 1'b1;
         q.push_back(e);
      end
   endtask

   task automatic send(input logic [W-1:0] d, input logic p);
      int n;
      @(negedge clk);
      load_data  = d;
      load_valid = 1'b1;
      n = 0;
      while (!load_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!load_ready) begin
         $display("FAIL accept_timeout: load_ready got 0, required 1 for word %h", d);
         total_cnt++;
         load_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         push_word(d, p);
         load_valid = 1'b0;
         $display("accepted word %h at t=%0t", d, $time);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || ser_valid) && n < 64) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", (q.size() == 0 && !ser_valid), 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = '{8'hA5, 1'b0, 2, 2};
      vec[1] = '{8'h2A, 1'b1, 2, 3};
      vec[2] = '{8'h07, 1'b1, 0, 0};
      vec[3] = '{8'h03, 1'b0, 0, 0};

      // Reset is honoured before any clock edge
      #3;
      check("rst_ser_valid", ser_valid, 0);
      check("rst_ser_out", ser_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_load_ready", load_ready, 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      foreach (vec[i]) begin
         det_cnt = 0;
         done_cnt = 0;
         max_run = 0;
         send(vec[i].data, vec[i].exp_parity);
         wait_idle();
         check("frame_len", max_run, PAR_EN ? W + 1 : W);
         check("done_pulses", done_cnt, 1);
         check("det_101", det_cnt, PAR_EN ? vec[i].exp_det_p : vec[i].exp_det);
         $display("frame %h: done pulses %0d, 101 hits %0d", vec[i].data, done_cnt, det_cnt);
      end

      // Back-to-back: second word waits until the final cycle of the first
      done_cnt = 0;
      max_run = 0;
      send(8'h05, 1'b0);
      send(8'hFF, 1'b0);
      wait_idle();
      check("b2b_run", max_run, PAR_EN ? 2 * (W + 1) : 2 * W);
      check("b2b_done", done_cnt, 2);
      $display("back-to-back 05,FF: contiguous run %0d", max_run);

      // Load pulse while busy must be ignored
      send(8'h80, 1'b1);
      repeat (3) @(negedge clk);
      check("busy_not_ready", load_ready, 0);
      load_data  = 8'h3C;
      load_valid = 1'b1;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      wait_idle();
      $display("ignored load 3C during frame 80");

      // Asynchronous reset mid-frame, with a load held across it
      send(8'hF0, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      load_data  = 8'h55;
      load_valid = 1'b1;
      #1;
      check("mid_rst_ser_valid", ser_valid, 0);
      check("mid_rst_ser_out", ser_out, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_load_ready", load_ready, 1);
      q.delete();
      @(posedge clk);
      #1;
      check("rst_accept_ignored", busy, 0);
      @(negedge clk);
      load_data = 8'hC3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      push_word(8'hC3, 1'b0);
      load_valid = 1'b0;
      $display("reset mid-frame F0, first word after release C3");
      wait_idle();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
